ex_hilo_muldiv: RTL and testbench

EX_HILO_MULDIV -- requirements
Module: ex_hilo_muldiv

---
 rtl/cpu_pkg.sv | 9 +
 rtl/div_iter.sv | 12 +
 rtl/ex_hilo_muldiv.sv | 130 +++++++++++++
 tb/tb_ex_hilo_muldiv.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: HI/LO multiply/divide op encodings and FSM state type shared across the EX stage.
package cpu_pkg;
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;
endpackage

// File: rtl/div_iter.sv
// div_iter: one radix-2 restoring divide step on a {remainder, quotient} 64-bit partial remainder.
module div_iter (
    input  logic [63:0] rem_i,
    input  logic [31:0] dvsr_i,
    output logic [63:0] rem_o
);
    logic [33:0] diff;
    always_comb begin
        diff  = {1'b0, rem_i[63:31]} - {2'b0, dvsr_i};
        rem_o = diff[33] ? {rem_i[62:0], 1'b0} : {diff[31:0], rem_i[30:0], 1'b1};
    end
endmodule

// File: rtl/ex_hilo_muldiv.sv
// ex_hilo_muldiv: EX-stage HI/LO unit (MULT/MULTU, MTHI/MTLO; DIV/DIVU when MULDIV_DIV_EN is defined).
module ex_hilo_muldiv
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_A,
    input  logic [31:0] ex_B,
    input  logic [1:0]  ex_whilo,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
);
    md_state_e   state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        is_mul, is_div, accept, mt, msgn;
    logic signed [65:0] ma, mb, prod;
    assign is_mul = (ex_op == MD_MULT) || (ex_op == MD_MULTU);
`ifdef MULDIV_DIV_EN
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d, rem_nx;
    logic [31:0] dvsr, quo, rmd;
    logic        sdiv;
    assign is_div = (ex_op == MD_DIV) || (ex_op == MD_DIVU);
    assign sdiv   = op_q == MD_DIV;
    assign dvsr   = (sdiv && b_q[31]) ? -b_q : b_q;
    div_iter u_div_iter (.rem_i(rem_q), .dvsr_i(dvsr), .rem_o(rem_nx));
    // Magnitude result is sign-corrected; divide by zero bypasses the datapath.
    assign quo = (b_q == 32'd0) ? 32'hFFFF_FFFF
               : (sdiv && (a_q[31] ^ b_q[31])) ? -rem_nx[31:0] : rem_nx[31:0];
    assign rmd = (b_q == 32'd0) ? a_q : (sdiv && a_q[31]) ? -rem_nx[63:32] : rem_nx[63:32];
`else
    assign is_div = 1'b0;
`endif
    assign accept = (state_q == S_IDLE) && ex_valid && (is_mul || is_div) && !flush;
    assign mt     = (state_q == S_IDLE) && ex_valid && !is_mul && !is_div && !flush;
    assign msgn   = op_q == MD_MULT;
    assign ma     = {{34{msgn & a_q[31]}}, a_q};
    assign mb     = {{34{msgn & b_q[31]}}, b_q};
    assign prod   = ma * mb;
    assign stall  = !reset && (accept || state_q == S_MUL || state_q == S_DIV);
    assign done   = !reset && state_q == S_DONE;
    assign hi     = hi_q;
    assign lo     = lo_q;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        cnt_d   = cnt_q;
        rem_d   = rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = ex_op;
                    a_d     = ex_A;
                    b_d     = ex_B;
                    state_d = is_mul ? S_MUL : S_DIV;
`ifdef MULDIV_DIV_EN
                    cnt_d   = 6'd0;
                    rem_d   = {32'b0, ((ex_op == MD_DIV && ex_A[31]) ? -ex_A : ex_A)};
`endif
                end else if (mt) begin
                    hi_d = ex_whilo[1] ? ex_A : hi_q;
                    lo_d = ex_whilo[0] ? ex_A : lo_q;
                end
            end
            S_MUL: begin
                {hi_d, lo_d} = prod[63:0];
                state_d      = S_DONE;
            end
            S_DIV: begin
`ifdef MULDIV_DIV_EN
                rem_d = rem_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    hi_d    = rmd;
                    lo_d    = quo;
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
`ifdef MULDIV_DIV_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 6'd0;
            rem_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end
`endif
endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// tb_ex_hilo_muldiv: table-driven check of HI/LO unit plus hand sequences for flush/reset corners.
module tb_ex_hilo_muldiv;
    logic        clk = 1'b0;
    logic        reset, ex_valid, flush;
    logic [2:0]  ex_op;
    logic [31:0] ex_A, ex_B;
    logic [1:0]  ex_whilo;
    logic        stall, done;
    logic [31:0] hi, lo;
    int          tests = 0;
    int          fails = 0;

    ex_hilo_muldiv dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_A(ex_A),
        .ex_B(ex_B), .ex_whilo(ex_whilo), .flush(flush), .stall(stall), .hi(hi),
        .lo(lo), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [1:0]  wh;
        int          ns;
        logic        dn;
        logic [31:0] ehi, elo;
    } vec_t;
    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds the instruction in EX until stall drops, then retires it at the next edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] wh, output int ns, output logic dn, output logic ok);
        logic st;
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_A = a; ex_B = b; ex_whilo = wh;
        ns = 0; dn = 1'b0; ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            st = stall;
            if (!st) dn = done;
            @(negedge clk);
            if (!st) begin
                ok = 1'b1;
                break;
            end
            ns++;
        end
        ex_valid = 1'b0; ex_op = 3'd0; ex_whilo = 2'd0;
    endtask

    task automatic run_vec(input vec_t x);
        int   ns;
        logic dn, ok;
        issue(x.op, x.a, x.b, x.wh, ns, dn, ok);
        chk({x.name, " timeout"}, {31'd0, ok}, 32'd1);
        chk({x.name, " stall cycles"}, ns, x.ns);
        chk({x.name, " done"}, {31'd0, dn}, {31'd0, x.dn});
        #1;
        chk({x.name, " hi"}, hi, x.ehi);
        chk({x.name, " lo"}, lo, x.elo);
        chk({x.name, " done low after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int   ns;
        logic dn, ok;
        logic [31:0] phi, plo;
        v.push_back('{"mthi", 3'd0, 32'h1234, 32'd0, 2'b10, 0, 1'b0, 32'h1234, 32'h0});
        v.push_back('{"mtlo", 3'd0, 32'h5678, 32'd0, 2'b01, 0, 1'b0, 32'h1234, 32'h5678});
        v.push_back('{"mult neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 2'b00, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        v.push_back('{"multu big", 3'd2, 32'hFFFF_FFFE, 32'd3, 2'b00, 2, 1'b1, 32'h2, 32'hFFFF_FFFA});
        v.push_back('{"mult 7x-1", 3'd1, 32'd7, 32'hFFFF_FFFF, 2'b00, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
        v.push_back('{"multu max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2, 1'b1, 32'hFFFF_FFFE, 32'h1});
        v.push_back('{"mult -3x-5", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 2'b00, 2, 1'b1, 32'h0, 32'd15});
        v.push_back('{"op5 mt both", 3'd5, 32'hAAAA, 32'd0, 2'b11, 0, 1'b0, 32'hAAAA, 32'hAAAA});
        v.push_back('{"mt both", 3'd0, 32'hBEEF, 32'd0, 2'b11, 0, 1'b0, 32'hBEEF, 32'hBEEF});
        v.push_back('{"op7 none", 3'd7, 32'h1111, 32'd9, 2'b00, 0, 1'b0, 32'hBEEF, 32'hBEEF});
`ifdef MULDIV_DIV_EN
        v.push_back('{"divu 100/7", 3'd4, 32'd100, 32'd7, 2'b00, 33, 1'b1, 32'd2, 32'd14});
        v.push_back('{"div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2, 2'b00, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        v.push_back('{"div 7/-2", 3'd3, 32'd7, 32'hFFFF_FFFE, 2'b00, 33, 1'b1, 32'd1, 32'hFFFF_FFFD});
        v.push_back('{"div 5/0", 3'd3, 32'd5, 32'd0, 2'b00, 33, 1'b1, 32'd5, 32'hFFFF_FFFF});
        v.push_back('{"div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 33, 1'b1, 32'd0, 32'h8000_0000});
        v.push_back('{"divu max/16", 3'd4, 32'hFFFF_FFFF, 32'h10, 2'b00, 33, 1'b1, 32'hF, 32'h0FFF_FFFF});
`else
        v.push_back('{"divu as none", 3'd4, 32'd100, 32'd7, 2'b00, 0, 1'b0, 32'hBEEF, 32'hBEEF});
        v.push_back('{"div as none", 3'd3, 32'd5, 32'd0, 2'b00, 0, 1'b0, 32'hBEEF, 32'hBEEF});
`endif
        reset = 1'b1; flush = 1'b0;
        ex_valid = 1'b1; ex_op = 3'd1; ex_A = 32'd5; ex_B = 32'd6; ex_whilo = 2'b11;
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset stall held", {31'd0, stall}, 32'd0);
        reset = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; ex_whilo = 2'd0;
        for (int i = 0; i < v.size(); i++) run_vec(v[i]);
        // Back-to-back MTHI then MTLO in consecutive cycles.
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd0; ex_whilo = 2'b10; ex_A = 32'h1234;
        #1 chk("b2b mthi stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        ex_whilo = 2'b01; ex_A = 32'h5678;
        #1 chk("b2b mtlo stall", {31'd0, stall}, 32'd0);
        chk("b2b hi mid", hi, 32'h1234);
        @(negedge clk);
        ex_valid = 1'b0; ex_whilo = 2'b00;
        #1 chk("b2b hi", hi, 32'h1234);
        chk("b2b lo", lo, 32'h5678);
        // MTHI/MTLO under flush are dropped.
        @(negedge clk);
        ex_valid = 1'b1; ex_whilo = 2'b11; ex_A = 32'hDEAD; flush = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_whilo = 2'b00; flush = 1'b0;
        #1 chk("flush mt hi", hi, 32'h1234);
        chk("flush mt lo", lo, 32'h5678);
        // Flush in the accept cycle.
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd1; ex_A = 32'd2; ex_B = 32'd3; flush = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 3'd0; flush = 1'b0;
        #1 chk("flush accept stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1 chk("flush accept done", {31'd0, done}, 32'd0);
        chk("flush accept lo", lo, 32'h5678);
        // Flush while in MUL.
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd1; ex_A = 32'd9; ex_B = 32'd9;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
        #1 chk("flush mul stall", {31'd0, stall}, 32'd0);
        chk("flush mul done", {31'd0, done}, 32'd0);
        chk("flush mul hi", hi, 32'h1234);
        chk("flush mul lo", lo, 32'h5678);
        // Flush in DONE keeps the written result.
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd1; ex_A = 32'd4; ex_B = 32'd5;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1 chk("flush done pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
        #1 chk("flush done lo", lo, 32'd20);
        chk("flush done hi", hi, 32'd0);
`ifdef MULDIV_DIV_EN
        // DIVU aborted by flush in DIV cycle 10.
        phi = hi; plo = lo;
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd4; ex_A = 32'd100; ex_B = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
        #1 chk("flush div stall", {31'd0, stall}, 32'd0);
        chk("flush div done", {31'd0, done}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            #1 if (done) chk("flush div late done", 32'd1, 32'd0);
        end
        chk("flush div hi", hi, phi);
        chk("flush div lo", lo, plo);
`endif
        issue(3'd1, 32'd2, 32'd3, 2'b00, ns, dn, ok);
        #1 chk("mult after flush lo", lo, 32'd6);
        chk("mult after flush stalls", ns, 2);
        // Reset mid-operation discards everything.
        @(negedge clk);
        ex_valid = 1'b1;
`ifdef MULDIV_DIV_EN
        ex_op = 3'd3; ex_A = 32'd1000; ex_B = 32'd3;
        repeat (5) @(negedge clk);
`else
        ex_op = 3'd1; ex_A = 32'd7; ex_B = 32'd8;
        @(negedge clk);
`endif
        reset = 1'b1;
        #1 chk("reset mid stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0; ex_valid = 1'b0; ex_op = 3'd0;
        #1 chk("reset mid hi", hi, 32'd0);
        chk("reset mid lo", lo, 32'd0);
        chk("reset mid stall after", {31'd0, stall}, 32'd0);
        chk("reset mid done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("reset mid lo later", lo, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
